// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: PC, imem req/ack, skid buffer, delay-slot redirects
//
// Owns the program counter and issues one word read at a time to instruction
// memory. Fetched words go to the IF/ID register, or into a one-entry skid
// buffer while ID stalls. Branch redirects are applied after the delay-slot
// word has been delivered.
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous active-high reset
//   stall          in   1   ID/EX hold; freezes if_pc/if_inst/if_valid
//   branch_flag    in   1   taken branch/jump from ID (sampled when stall=0)
//   branch_target  in  32   redirect address (bits [1:0] ignored)
//   imem_req       out  1   read request
//   imem_addr      out 32   read word address (= pc)
//   imem_ack       in   1   read complete, imem_rdata valid
//   imem_rdata     in  32   instruction word
//   if_pc          out 32   PC of instruction presented to ID
//   if_inst        out 32   instruction presented to ID (0 when invalid)
//   if_valid       out  1   if_inst is a real fetched word
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam logic ST_FETCH    = 1'b0;
  localparam logic ST_BUFFERED = 1'b1;

  logic        state_q,       state_d;
  logic [31:0] pc_q,          pc_d;
  logic [31:0] buf_pc_q,      buf_pc_d;
  logic [31:0] buf_inst_q,    buf_inst_d;
  logic        pend_valid_q,  pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] if_pc_q,       if_pc_d;
  logic [31:0] if_inst_q,     if_inst_d;
  logic        if_valid_q,    if_valid_d;

  logic [31:0] target_aligned;
  logic [31:0] next_pc;

  assign target_aligned = {branch_target[31:2], 2'b00};
  // A pending redirect captured while the delay slot was outstanding takes
  // the place of the sequential successor once that delay slot returns.
  assign next_pc        = pend_valid_q ? pend_target_q : (pc_q + 32'd4);

  assign imem_req  = ~rst & (state_q == ST_FETCH);
  assign imem_addr = pc_q;

  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign if_valid  = if_valid_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_pc_d      = buf_pc_q;
    buf_inst_d    = buf_inst_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if_pc_d       = if_pc_q;
    if_inst_d     = if_inst_q;
    if_valid_d    = if_valid_q;

    if (state_q == ST_FETCH) begin
      if (imem_ack) begin
        pend_valid_d = 1'b0;
        pc_d         = next_pc;
        if (!stall) begin
          if_pc_d    = pc_q;
          if_inst_d  = imem_rdata;
          if_valid_d = 1'b1;
          // The word just delivered is the delay slot, so the target is next.
          if (branch_flag) begin
            pc_d = target_aligned;
          end
        end else begin
          buf_pc_d   = pc_q;
          buf_inst_d = imem_rdata;
          state_d    = ST_BUFFERED;
        end
      end else if (!stall) begin
        if_valid_d = 1'b0;
        if_inst_d  = 32'd0;
        // Delay slot still in flight: remember the target, keep imem_addr stable.
        if (branch_flag) begin
          pend_valid_d  = 1'b1;
          pend_target_d = target_aligned;
        end
      end
    end else begin
      if (!stall) begin
        if_pc_d    = buf_pc_q;
        if_inst_d  = buf_inst_q;
        if_valid_d = 1'b1;
        state_d    = ST_FETCH;
        // The buffered word being drained is the delay slot.
        if (branch_flag) begin
          pc_d = target_aligned;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      buf_pc_q      <= 32'd0;
      buf_inst_q    <= 32'd0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'd0;
      if_pc_q       <= 32'd0;
      if_inst_q     <= 32'd0;
      if_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_pc_q      <= buf_pc_d;
      buf_inst_q    <= buf_inst_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      if_pc_q       <= if_pc_d;
      if_inst_q     <= if_inst_d;
      if_valid_q    <= if_valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed table-driven bench for if_fetch
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int passed = 0;
  int total  = 0;

  if_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_valid      (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row per cycle: inputs driven for that cycle, and the outputs expected
  // during that cycle (registered ones reflect earlier edges, req/addr are
  // combinational from current state).
  typedef struct {
    logic        rst;
    logic        stall;
    logic        bf;
    logic [31:0] bt;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic bf, input logic [31:0] bt,
                     input logic ack, input logic [31:0] rd,
                     input logic [31:0] epc, input logic [31:0] einst, input logic ev,
                     input logic ereq, input logic [31:0] eaddr);
    vec_t v;
    v.rst = r; v.stall = s; v.bf = bf; v.bt = bt; v.ack = ack; v.rdata = rd;
    v.e_pc = epc; v.e_inst = einst; v.e_valid = ev; v.e_req = ereq; v.e_addr = eaddr;
    vecs.push_back(v);
  endtask

  task automatic check32(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL row%0d %s: got %08h expected %08h", row, name, act, exp);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;

    //   rst s  bf target         ack rdata           if_pc          if_inst        v  req addr
    add(1, 0, 0, 32'h0,          1, 32'hDEADBEEF, 32'h0,          32'h0,          0, 0, 32'hBFC00000);
    add(0, 0, 0, 32'h0,          1, 32'h3C011234, 32'h0,          32'h0,          0, 1, 32'hBFC00000);
    add(0, 0, 1, 32'h80000008,   0, 32'h0,        32'hBFC00000,   32'h3C011234,   1, 1, 32'hBFC00004);
    add(0, 0, 0, 32'h0,          1, 32'h11111111, 32'hBFC00000,   32'h0,          0, 1, 32'hBFC00004);
    add(0, 0, 0, 32'h0,          0, 32'h0,        32'hBFC00004,   32'h11111111,   1, 1, 32'h80000008);
    add(0, 0, 0, 32'h0,          0, 32'h0,        32'hBFC00004,   32'h0,          0, 1, 32'h80000008);
    add(0, 0, 0, 32'h0,          0, 32'h0,        32'hBFC00004,   32'h0,          0, 1, 32'h80000008);
    add(0, 0, 0, 32'h0,          1, 32'h22222222, 32'hBFC00004,   32'h0,          0, 1, 32'h80000008);
    add(0, 0, 1, 32'h80000013,   1, 32'h33333333, 32'h80000008,   32'h22222222,   1, 1, 32'h8000000C);
    add(0, 0, 0, 32'h0,          1, 32'h44444444, 32'h8000000C,   32'h33333333,   1, 1, 32'h80000010);
    add(0, 0, 1, 32'h80000100,   1, 32'h55555555, 32'h80000010,   32'h44444444,   1, 1, 32'h80000014);
    add(0, 0, 1, 32'h80000020,   1, 32'h66666666, 32'h80000014,   32'h55555555,   1, 1, 32'h80000100);
    add(0, 1, 0, 32'h0,          1, 32'h24020005, 32'h80000100,   32'h66666666,   1, 1, 32'h80000020);
    add(0, 1, 0, 32'h0,          1, 32'hBADBAD00, 32'h80000100,   32'h66666666,   1, 0, 32'h80000024);
    add(0, 0, 0, 32'h0,          0, 32'h0,        32'h80000100,   32'h66666666,   1, 0, 32'h80000024);
    add(0, 0, 0, 32'h0,          0, 32'h0,        32'h80000020,   32'h24020005,   1, 1, 32'h80000024);
    add(0, 0, 0, 32'h0,          1, 32'h77777777, 32'h80000020,   32'h0,          0, 1, 32'h80000024);
    add(0, 0, 1, 32'h80000200,   0, 32'h0,        32'h80000024,   32'h77777777,   1, 1, 32'h80000028);
    add(0, 0, 0, 32'h0,          0, 32'h0,        32'h80000024,   32'h0,          0, 1, 32'h80000028);
    add(0, 0, 0, 32'h0,          1, 32'h88888888, 32'h80000024,   32'h0,          0, 1, 32'h80000028);
    add(0, 1, 1, 32'h80000300,   0, 32'h0,        32'h80000028,   32'h88888888,   1, 1, 32'h80000200);
    add(0, 0, 0, 32'h0,          1, 32'h99999999, 32'h80000028,   32'h88888888,   1, 1, 32'h80000200);
    add(0, 0, 1, 32'h80000400,   0, 32'h0,        32'h80000200,   32'h99999999,   1, 1, 32'h80000204);
    add(0, 0, 1, 32'h80000500,   0, 32'h0,        32'h80000200,   32'h0,          0, 1, 32'h80000204);
    add(0, 1, 0, 32'h0,          1, 32'hAAAAAAAA, 32'h80000200,   32'h0,          0, 1, 32'h80000204);
    add(0, 0, 0, 32'h0,          0, 32'h0,        32'h80000200,   32'h0,          0, 0, 32'h80000500);
    add(0, 0, 1, 32'hFFFFFFFC,   1, 32'hBBBBBBBB, 32'h80000204,   32'hAAAAAAAA,   1, 1, 32'h80000500);
    add(0, 0, 0, 32'h0,          1, 32'hCCCCCCCC, 32'h80000500,   32'hBBBBBBBB,   1, 1, 32'hFFFFFFFC);
    add(0, 0, 1, 32'h80000700,   0, 32'h0,        32'hFFFFFFFC,   32'hCCCCCCCC,   1, 1, 32'h00000000);
    add(0, 1, 0, 32'h0,          1, 32'hDDDDDDDD, 32'hFFFFFFFC,   32'h0,          0, 1, 32'h00000000);
    add(1, 1, 0, 32'h0,          0, 32'h0,        32'hFFFFFFFC,   32'h0,          0, 0, 32'h80000700);
    add(0, 0, 0, 32'h0,          0, 32'h0,        32'h0,          32'h0,          0, 1, 32'hBFC00000);
    add(0, 0, 0, 32'h0,          1, 32'hEEEEEEEE, 32'h0,          32'h0,          0, 1, 32'hBFC00000);
    add(0, 0, 0, 32'h0,          0, 32'h0,        32'hBFC00000,   32'hEEEEEEEE,   1, 1, 32'hBFC00004);
    add(0, 1, 0, 32'h0,          1, 32'h12345678, 32'hBFC00000,   32'h0,          0, 1, 32'hBFC00004);
    add(0, 0, 1, 32'h80000800,   0, 32'h0,        32'hBFC00000,   32'h0,          0, 0, 32'hBFC00008);
    add(0, 0, 0, 32'h0,          0, 32'h0,        32'hBFC00004,   32'h12345678,   1, 1, 32'h80000800);

    // Hand sequence: hold reset across two edges, outputs must be cleared.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    check32("reset if_valid", -1, {31'd0, if_valid}, 32'd0);
    check32("reset if_pc",    -1, if_pc,  32'd0);
    check32("reset imem_req", -1, {31'd0, imem_req}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst           = vecs[i].rst;
      stall         = vecs[i].stall;
      branch_flag   = vecs[i].bf;
      branch_target = vecs[i].bt;
      imem_ack      = vecs[i].ack;
      imem_rdata    = vecs[i].rdata;
      #2;
      check32("if_pc",     i, if_pc,               vecs[i].e_pc);
      check32("if_inst",   i, if_inst,             vecs[i].e_inst);
      check32("if_valid",  i, {31'd0, if_valid},   {31'd0, vecs[i].e_valid});
      check32("imem_req",  i, {31'd0, imem_req},   {31'd0, vecs[i].e_req});
      check32("imem_addr", i, imem_addr,           vecs[i].e_addr);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
